// File: rtl/decode_window_buffer.sv
// Circular byte buffer between fetch and decode: presents a byte-aligned window at the
// current instruction start, tracks its PC, and pre-scans legacy/REX prefixes.
module decode_window_buffer #(
    parameter int          BUF_BYTES    = 32,
    parameter int          FETCH_BYTES  = 8,
    parameter int          WINDOW_BYTES = 15,
    parameter int          MAX_PREFIXES = 4,
    parameter logic [63:0] RESET_PC     = 64'h0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  fetch_valid,
    output logic                                  fetch_ready,
    input  logic [FETCH_BYTES*8-1:0]              fetch_data,
    input  logic                                  redirect_valid,
    input  logic [63:0]                           redirect_pc,
    output logic [WINDOW_BYTES*8-1:0]             window_bytes,
    output logic [$clog2(BUF_BYTES+1)-1:0]        window_count,
    output logic [63:0]                           window_pc,
    input  logic                                  consume_valid,
    input  logic [3:0]                            consume_len,
    output logic                                  consume_error,
    output logic [$clog2(MAX_PREFIXES+1)-1:0]     prefix_cnt,
    output logic                                  prefix_overflow,
    output logic                                  rex_present,
    output logic                                  scan_done
);

    localparam int AW = $clog2(BUF_BYTES);
    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int PW = $clog2(MAX_PREFIXES + 1);

    logic [7:0]    mem_q [BUF_BYTES];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_q, pc_d;
    logic          cerr_q, cerr_d;

    logic          push;
    logic          consume_ok;
    logic          consume_bad;
    logic [7:0]    wb [WINDOW_BYTES];
    logic [PW-1:0] pcnt;
    logic          stop;
    logic [7:0]    rex_byte;

    function automatic logic is_legacy_prefix(input logic [7:0] b);
        case (b)
            8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h3E, 8'h26,
            8'h64, 8'h65, 8'h36, 8'h66, 8'h67: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    always_comb begin
        fetch_ready = !reset && !redirect_valid && (count_q <= CW'(BUF_BYTES - FETCH_BYTES));
        push        = fetch_valid && fetch_ready;
        consume_ok  = consume_valid && (consume_len != 4'd0) && (CW'(consume_len) <= count_q);
        consume_bad = consume_valid && !consume_ok;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        cerr_d  = 1'b0;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = redirect_pc;
        end else begin
            cerr_d = consume_bad;
            if (push) begin
                tail_d = tail_q + AW'(FETCH_BYTES);
            end
            if (consume_ok) begin
                head_d = head_q + AW'(consume_len);
                pc_d   = pc_q + 64'(consume_len);
            end
            count_d = count_q + (push ? CW'(FETCH_BYTES) : CW'(0))
                              - (consume_ok ? CW'(consume_len) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            cerr_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            cerr_q  <= cerr_d;
        end
    end

    // Byte storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < FETCH_BYTES; j++) begin
                mem_q[tail_q + AW'(j)] <= fetch_data[FETCH_BYTES*8-1-8*j -: 8];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            wb[k] = (CW'(k) < count_q) ? mem_q[head_q + AW'(k)] : 8'h00;
            window_bytes[WINDOW_BYTES*8-1-8*k -: 8] = wb[k];
        end
    end

    always_comb begin
        pcnt = PW'(MAX_PREFIXES);
        stop = 1'b0;
        for (int k = 0; k < MAX_PREFIXES; k++) begin
            if (!stop && ((CW'(k) >= count_q) || !is_legacy_prefix(wb[k]))) begin
                pcnt = PW'(k);
                stop = 1'b1;
            end
        end
        rex_byte = wb[0];
        for (int k = 0; k <= MAX_PREFIXES; k++) begin
            if (PW'(k) == pcnt) begin
                rex_byte = wb[k];
            end
        end
        scan_done       = count_q > CW'(pcnt);
        prefix_overflow = (pcnt == PW'(MAX_PREFIXES)) && (count_q > CW'(MAX_PREFIXES))
                          && is_legacy_prefix(wb[MAX_PREFIXES]);
        rex_present     = !prefix_overflow && scan_done && (rex_byte[7:4] == 4'h4);
    end

    assign window_count  = count_q;
    assign window_pc     = pc_q;
    assign consume_error = cerr_q;
    assign prefix_cnt    = pcnt;

endmodule

// File: tb/tb_decode_window_buffer.sv
// Bench for decode_window_buffer: directed scenarios plus randomized traffic checked
// every cycle against a byte-queue reference model.
module tb_decode_window_buffer;

    localparam int          BUF_BYTES    = 32;
    localparam int          FETCH_BYTES  = 8;
    localparam int          WINDOW_BYTES = 15;
    localparam int          MAX_PREFIXES = 4;
    localparam logic [63:0] RESET_PC     = 64'h1000;

    logic                         clk;
    logic                         reset;
    logic                         fetch_valid;
    logic                         fetch_ready;
    logic [FETCH_BYTES*8-1:0]     fetch_data;
    logic                         redirect_valid;
    logic [63:0]                  redirect_pc;
    logic [WINDOW_BYTES*8-1:0]    window_bytes;
    logic [5:0]                   window_count;
    logic [63:0]                  window_pc;
    logic                         consume_valid;
    logic [3:0]                   consume_len;
    logic                         consume_error;
    logic [2:0]                   prefix_cnt;
    logic                         prefix_overflow;
    logic                         rex_present;
    logic                         scan_done;

    decode_window_buffer #(
        .BUF_BYTES(BUF_BYTES), .FETCH_BYTES(FETCH_BYTES), .WINDOW_BYTES(WINDOW_BYTES),
        .MAX_PREFIXES(MAX_PREFIXES), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .window_bytes(window_bytes), .window_count(window_count), .window_pc(window_pc),
        .consume_valid(consume_valid), .consume_len(consume_len), .consume_error(consume_error),
        .prefix_cnt(prefix_cnt), .prefix_overflow(prefix_overflow),
        .rex_present(rex_present), .scan_done(scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0]  mq[$];
    logic [63:0] mpc;
    logic        mcerr;
    logic [7:0]  PFX [11] = '{8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h3E, 8'h26,
                              8'h64, 8'h65, 8'h36, 8'h66, 8'h67};

    function automatic bit is_pfx(input logic [7:0] b);
        foreach (PFX[i]) if (PFX[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return PFX[$urandom_range(0, 10)];
            1:       return 8'h40 | 8'($urandom_range(0, 15));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rand_beat();
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[63-8*j -: 8] = rand_byte();
        return d;
    endfunction

    task automatic model_update();
        int sz;
        bit legal;
        bit pushed;
        if (reset) begin
            mq.delete(); mpc = RESET_PC; mcerr = 1'b0;
        end else if (redirect_valid) begin
            mq.delete(); mpc = redirect_pc; mcerr = 1'b0;
        end else begin
            sz     = mq.size();
            legal  = consume_valid && consume_len >= 1 && int'(consume_len) <= sz;
            pushed = fetch_valid && sz <= BUF_BYTES - FETCH_BYTES;
            if (legal) begin
                repeat (consume_len) void'(mq.pop_front());
                mpc = mpc + 64'(consume_len);
            end
            if (pushed)
                for (int j = 0; j < FETCH_BYTES; j++) mq.push_back(fetch_data[FETCH_BYTES*8-1-8*j -: 8]);
            mcerr = consume_valid && !legal;
        end
    endtask

    task automatic check_all();
        logic [119:0] ewin;
        int ep;
        bit eovf, edone, erex, eready;
        ewin = '0;
        for (int k = 0; k < WINDOW_BYTES && k < mq.size(); k++) ewin[119-8*k -: 8] = mq[k];
        ep = 0;
        while (ep < MAX_PREFIXES && ep < mq.size() && is_pfx(mq[ep])) ep++;
        eovf  = (ep == MAX_PREFIXES) && (mq.size() > MAX_PREFIXES) && is_pfx(mq[MAX_PREFIXES]);
        edone = mq.size() > ep;
        erex  = 1'b0;
        if (edone && !eovf) erex = (mq[ep][7:4] == 4'h4);
        eready = !reset && !redirect_valid && (mq.size() <= BUF_BYTES - FETCH_BYTES);
        check("count",    window_count,    mq.size());
        check("pc",       window_pc,       mpc);
        check("window",   window_bytes,    ewin);
        check("ready",    fetch_ready,     eready);
        check("cerr",     consume_error,   mcerr);
        check("pcnt",     prefix_cnt,      ep);
        check("overflow", prefix_overflow, eovf);
        check("rex",      rex_present,     erex);
        check("done",     scan_done,       edone);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        fetch_valid = 0; consume_valid = 0; consume_len = 0; redirect_valid = 0;
    endtask

    task automatic push_beat(input logic [63:0] d);
        idle(); fetch_valid = 1; fetch_data = d; cycle(); idle();
    endtask

    task automatic consume(input logic [3:0] len);
        idle(); consume_valid = 1; consume_len = len; cycle(); idle();
    endtask

    task automatic redirect(input logic [63:0] pc);
        idle(); redirect_valid = 1; redirect_pc = pc; cycle(); idle();
    endtask

    initial begin
        idle(); fetch_data = '0; redirect_pc = '0;
        mpc = RESET_PC; mcerr = 0;
        reset = 1; cycle(); cycle();
        check("rst_count", window_count, 0);
        check("rst_pc",    window_pc,    64'h1000);
        reset = 0; #1;
        check("rst_ready", fetch_ready, 1);

        push_beat(64'h0F05_9090_9090_9090);
        check("beat_count", window_count, 8);
        check("beat_b01",   window_bytes[119 -: 16], 16'h0F05);
        check("beat_pc",    window_pc, 64'h1000);
        check("beat_done",  scan_done, 1);

        redirect(64'h2000);
        push_beat(64'hF366_4889_C800_0000);
        check("pfx2_cnt", prefix_cnt, 2);
        check("pfx2_rex", rex_present, 1);
        consume(5);
        check("adv_pc",    window_pc, 64'h2005);
        check("adv_count", window_count, 3);

        redirect(64'h3000);
        push_beat(64'h6666_6666_6690_9090);
        check("ovf_flag", prefix_overflow, 1);
        check("ovf_rex",  rex_present, 0);
        redirect(64'h3000);
        push_beat(64'h9090_9090_6666_6666);
        consume(4);
        check("four_cnt",  prefix_cnt, 4);
        check("four_ovf",  prefix_overflow, 0);
        check("four_done", scan_done, 0);

        consume(6);
        check("bad6_err",   consume_error, 1);
        check("bad6_count", window_count, 4);
        cycle();
        check("bad6_pulse", consume_error, 0);
        consume(0);
        check("bad0_err", consume_error, 1);
        cycle();

        redirect(64'h4000);
        repeat (3) push_beat(rand_beat());
        idle(); fetch_valid = 1; fetch_data = rand_beat(); consume_valid = 1; consume_len = 7;
        cycle(); idle();
        check("full_count", window_count, 25);
        check("full_ready", fetch_ready, 0);
        fetch_valid = 1; fetch_data = rand_beat(); consume_valid = 1; consume_len = 15;
        cycle(); idle();
        check("drain_count", window_count, 10);
        check("drain_ready", fetch_ready, 1);

        for (int c = 0; c < 100; c++) begin
            fetch_valid = 1; fetch_data = rand_beat();
            consume_valid = (mq.size() >= 3); consume_len = 3;
            cycle();
        end
        idle();

        fetch_valid = 1; fetch_data = rand_beat(); consume_valid = 1; consume_len = 1;
        redirect_valid = 1; redirect_pc = 64'hFFFF_0000;
        cycle(); idle(); #1;
        check("redir_count", window_count, 0);
        check("redir_pc",    window_pc, 64'hFFFF_0000);
        check("redir_win",   window_bytes, 0);
        check("redir_ready", fetch_ready, 1);
        check("redir_err",   consume_error, 0);

        for (int c = 0; c < 600; c++) begin
            fetch_valid    = ($urandom_range(0, 9) < 7);
            fetch_data     = rand_beat();
            consume_valid  = $urandom_range(0, 1);
            consume_len    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 6));
            redirect_valid = ($urandom_range(0, 49) == 0);
            redirect_pc    = {$urandom, $urandom};
            reset          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 0; idle();

        repeat (2) push_beat(rand_beat());
        reset = 1; fetch_valid = 1; consume_valid = 1; consume_len = 2;
        cycle(); reset = 0; idle();
        check("mid_rst_count", window_count, 0);
        check("mid_rst_pc",    window_pc, 64'h1000);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_window_buffer.md
Name: decode_window_buffer

Overview:
- Parametrised successor to the single-shot instruction decoder front end.
- Circular byte buffer between fetch and decode. Accepts fixed-width fetch chunks and presents a byte-aligned window at the current instruction start to the decoder.
- Advances by the decoded length and tracks the instruction PC. Pre-scans legacy/REX prefixes with a configurable prefix limit and explicit overflow reporting, so decode no longer silently stops at 4 prefixes.
- Supports redirect/flush from branch resolution.

Parameters:
- BUF_BYTES, 32, buffer capacity in bytes; power of 2, ≥ WINDOW_BYTES + FETCH_BYTES.
- FETCH_BYTES, 8, bytes per fetch beat; power of 2.
- WINDOW_BYTES, 15, bytes presented to the decoder (maximum x86 instruction length).
- MAX_PREFIXES, 4, legacy prefixes accepted before overflow; 1..WINDOW_BYTES-1.
- RESET_PC, 64'h0, window_pc value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_valid  in  1  fetch beat offered
- fetch_ready  out  1  buffer accepts beat this cycle
- fetch_data  in  FETCH_BYTES*8  beat bytes; byte 0 in bits [FETCH_BYTES*8-1 -: 8] (big-endian byte order)
- redirect_valid  in  1  flush buffer, restart at redirect_pc
- redirect_pc  in  64  new instruction PC
- window_bytes  out  WINDOW_BYTES*8  bytes from head; byte 0 in MSBs; invalid bytes read 0
- window_count  out  $clog2(BUF_BYTES+1)  valid bytes in buffer (not clamped)
- window_pc  out  64  PC of window byte 0
- consume_valid  in  1  decoder retires an instruction
- consume_len  in  4  bytes consumed, 1..15
- consume_error  out  1  previous cycle's consume was illegal
- prefix_cnt  out  $clog2(MAX_PREFIXES+1)  leading legacy prefix bytes, saturated at MAX_PREFIXES
- prefix_overflow  out  1  byte at index MAX_PREFIXES is also a legacy prefix
- rex_present  out  1  byte at index prefix_cnt is 0x4X
- scan_done  out  1  prefix/REX outputs final (enough valid bytes)

Behaviour:
- State: head, tail (log2 BUF_BYTES, wrap modulo BUF_BYTES), count, pc, consume_error. Reset: head = tail = count = 0, pc = RESET_PC, consume_error = 0; so fetch_ready = 1 and all scan outputs = 0. Reset overrides all inputs.
- fetch_ready = !reset && !redirect_valid && (count <= BUF_BYTES - FETCH_BYTES), using registered count only; a same-cycle consume does not raise it.
- Push when fetch_valid && fetch_ready: write FETCH_BYTES bytes at tail..tail+FETCH_BYTES-1 (wrapping); tail += FETCH_BYTES.
- Legal consume: consume_valid && 1 ≤ consume_len ≤ 15 && consume_len ≤ count. Effect: head += consume_len; pc += consume_len (64-bit wrap).
- Illegal consume (len 0, len > count): no state change except consume_error = 1 next cycle. consume_error is otherwise 0 and is a one-cycle pulse.
- Same-cycle push and legal consume: count_next = count + FETCH_BYTES - consume_len.
- Redirect (priority below reset): head = tail = count = 0, pc = redirect_pc. Push and consume that cycle are ignored; consume_error = 0 next cycle.
- Outputs window_*, prefix_*, rex_present, scan_done: combinational from registered state only; zero latency from the state update.
- Legacy prefix set: F0 F2 F3 2E 3E 26 64 65 36 66 67.
- Scan:
  - i = first index in 0..MAX_PREFIXES-1 that is invalid (i ≥ count) or a non-prefix; prefix_cnt = i, else MAX_PREFIXES.
  - prefix_overflow = (prefix_cnt == MAX_PREFIXES) && count > MAX_PREFIXES && byte[MAX_PREFIXES] is a prefix.
  - rex_present = !prefix_overflow && count > prefix_cnt && byte[prefix_cnt][7:4] == 4.
  - scan_done = count > prefix_cnt, i.e. the terminating byte is valid.
- When count ≥ WINDOW_BYTES, all window bytes are valid. Wrap-around reads must be seamless across the buffer end.

Test Plan:
- Reset, push beat 0x0F05_9090_9090_9090 at RESET_PC=0x1000 -> next cycle window_count=8, window_bytes[0..1]=0F 05, window_pc=0x1000, prefix_cnt=0, scan_done=1, rex_present=0.
- Bytes F3 66 48 89 C8 valid; consume 5 -> prefix_cnt=2, rex_present=1; after consume window_pc advances by 5 and head advances 5.
- Five leading 0x66 with MAX_PREFIXES=4 -> prefix_cnt=4, prefix_overflow=1, rex_present=0. With only 4 bytes valid -> overflow=0, scan_done=0.
- Fill to count=25 (BUF 32, FETCH 8) -> fetch_ready=0. Consume 15 the same cycle -> beat not accepted. Next cycle count=10, fetch_ready=1. Keep pushing/consuming 3-byte instructions for 100 cycles -> window byte stream matches pushed stream across wrap.
- consume_len=6 with count=4 -> state unchanged, consume_error=1 for exactly one cycle. consume_len=0 -> same.
- redirect_valid with redirect_pc=0xFFFF_0000 together with fetch_valid and a legal consume -> next cycle count=0, window_pc=0xFFFF_0000, window_bytes=0, fetch_ready=1, consume_error=0. Reset asserted mid-stream -> all state returns to reset values.
